// File: rtl/noc_pkg.sv
// Shared NoC flit definitions: flit type encoding, default widths, packet FSM
// states and header field extraction helpers.
package noc_pkg;

  localparam int FLIT_W_DEF = 34;
  localparam int DEST_W_DEF = 4;

  typedef enum logic [1:0] {
    BODY      = 2'b00,
    TAIL      = 2'b01,
    HEAD      = 2'b10,
    HEAD_TAIL = 2'b11
  } flit_type_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_ACTIVE = 2'd2
  } pkt_state_t;

  // Type sits in the two MSBs, destination directly below it.
  function automatic flit_type_t get_type(input logic [FLIT_W_DEF-1:0] flit);
    return flit_type_t'(flit[FLIT_W_DEF-1 -: 2]);
  endfunction

  function automatic logic [DEST_W_DEF-1:0] get_dest(input logic [FLIT_W_DEF-1:0] flit);
    return flit[FLIT_W_DEF-3 -: DEST_W_DEF];
  endfunction

endpackage

// File: rtl/input_buffer_if.sv
// Link, switch-allocation and crossbar signals of one router input port.
interface input_buffer_if
  import noc_pkg::*;
#(
  parameter int FLIT_W = FLIT_W_DEF,
  parameter int DEST_W = DEST_W_DEF
);

  logic [FLIT_W-1:0] flit_i;
  logic              flit_valid_i;
  logic              credit_o;
  logic              req_o;
  logic [DEST_W-1:0] dest_o;
  logic              gnt_i;
  logic [FLIT_W-1:0] flit_o;
  logic              out_valid_o;
  logic              read_i;
  logic              err_o;

  modport slave (
    input  flit_i, flit_valid_i, gnt_i, read_i,
    output credit_o, req_o, dest_o, flit_o, out_valid_o, err_o
  );

  modport master (
    output flit_i, flit_valid_i, gnt_i, read_i,
    input  credit_o, req_o, dest_o, flit_o, out_valid_o, err_o
  );

endinterface

// File: rtl/flit_fifo.sv
// Synchronous flit FIFO; a push into a full FIFO is accepted only when a pop
// happens in the same cycle, otherwise it is dropped and flagged.
module flit_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] data,
  output logic [W-1:0] front,
  output logic         full,
  output logic         empty,
  output logic         overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && full && !do_pop;
  assign front    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data;
  end

endmodule

// File: rtl/input_buffer.sv
// NoC router input port: flit FIFO, per-packet route/grant/forward FSM,
// credit return to the upstream router and a sticky protocol-error flag.
module input_buffer
  import noc_pkg::*;
#(
  parameter int FLIT_W = FLIT_W_DEF,
  parameter int DEST_W = DEST_W_DEF,
  parameter int DEPTH  = 4
) (
  input logic            clk,
  input logic            rst,
  input_buffer_if.slave  bus
);

  pkt_state_t        state;
  pkt_state_t        state_nxt;
  logic [FLIT_W-1:0] fifo_front;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_overflow;
  flit_type_t        front_type;
  logic              pop;
  logic              req;
  logic              out_valid;
  logic              dest_load;
  logic              err_fsm;
  logic              in_body;
  logic [DEST_W-1:0] dest_q;
  logic              credit_q;
  logic              err_q;

  flit_fifo #(
    .W     (FLIT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (bus.flit_valid_i),
    .pop      (pop),
    .data     (bus.flit_i),
    .front    (fifo_front),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .overflow (fifo_overflow)
  );

  assign front_type = get_type(fifo_front);

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    req       = 1'b0;
    out_valid = 1'b0;
    dest_load = 1'b0;
    err_fsm   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          if (front_type == HEAD || front_type == HEAD_TAIL) begin
            dest_load = 1'b1;
            state_nxt = S_REQ;
          end else begin
            pop     = 1'b1;
            err_fsm = 1'b1;
          end
        end
      end
      S_REQ: begin
        req = 1'b1;
        if (bus.gnt_i) state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        out_valid = !fifo_empty;
        if (out_valid && bus.read_i) begin
          pop = 1'b1;
          if (front_type == TAIL || front_type == HEAD_TAIL) state_nxt = S_IDLE;
          // The packet's own head is the first pop; any later HEAD is foreign.
          if (front_type == HEAD && in_body) err_fsm = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      dest_q   <= '0;
      credit_q <= 1'b0;
      err_q    <= 1'b0;
      in_body  <= 1'b0;
    end else begin
      state    <= state_nxt;
      credit_q <= pop;
      err_q    <= err_q | err_fsm | fifo_overflow;
      if (dest_load) dest_q <= get_dest(fifo_front);
      if (state != S_ACTIVE) in_body <= 1'b0;
      else if (pop)          in_body <= 1'b1;
    end
  end

  assign bus.credit_o    = credit_q;
  assign bus.req_o       = req;
  assign bus.dest_o      = dest_q;
  assign bus.flit_o      = fifo_front;
  assign bus.out_valid_o = out_valid;
  assign bus.err_o       = err_q;

endmodule

// File: doc/input_buffer.md
Name: input_buffer

Overview:
Per-port input buffer of a NoC router. It receives flits from the upstream router's link and stores them in a DEPTH-entry FIFO. It runs a per-packet state machine (route request, switch grant, flit forwarding). Every dequeued flit returns one credit pulse to the upstream router's credit counter, whose initial credit equals DEPTH.

Parameters:
FLIT_W, 34, flit width in bits; [FLIT_W-1:FLIT_W-2] = flit type, [FLIT_W-3:FLIT_W-2-DEST_W] = destination.
DEST_W, 4, destination field width.
DEPTH, 4, FIFO entries; must equal the upstream credit counter's initial credit.

Ports:
clk  input  1  clock; all logic is sampled on its rising edge.
rst  input  1  reset, synchronous, active-high.
flit_i  input  FLIT_W  flit from the upstream link.
flit_valid_i  input  1  flit_i is valid this cycle (write request).
credit_o  output  1  one-cycle credit-return pulse; connects to the upstream counter's incr_i.
req_o  output  1  switch allocation request for the packet at the FIFO head.
dest_o  output  DEST_W  destination of the requesting or active packet.
gnt_i  input  1  switch grant for this port.
flit_o  output  FLIT_W  flit at the FIFO front.
out_valid_o  output  1  flit_o is forwardable this cycle.
read_i  input  1  crossbar consumes flit_o this cycle.
err_o  output  1  sticky protocol-error flag.

Behaviour:
- Reset values: credit_o=0, req_o=0, out_valid_o=0, err_o=0, dest_o=0, FIFO empty, state=IDLE. Reset mid-packet drops all stored flits and returns no credits; the upstream counter shares rst.
- Flit types: HEAD=2'b10, BODY=2'b00, TAIL=2'b01, HEAD_TAIL=2'b11.
- Write: flit_valid_i with FIFO not full stores flit_i. Write latency: a flit written at cycle t into an empty FIFO appears on flit_o at t+1.
- Write while full:
  - If a pop occurs in the same cycle, the write is accepted and the count is unchanged.
  - Otherwise the flit is dropped and err_o is set.
- Pop sources (at most one pop per cycle):
  - ACTIVE with out_valid_o && read_i.
  - IDLE discard (see below).
- Credit return: credit_o=1 in the cycle after each pop, otherwise 0. Exactly one credit pulse per popped flit; dropped flits return no credit.
- State IDLE:
  - FIFO empty: stay in IDLE.
  - Front is HEAD or HEAD_TAIL: latch its destination into dest_o, go to REQ next cycle.
  - Front is BODY or TAIL: pop/discard it, set err_o, stay in IDLE.
- State REQ:
  - req_o=1 and dest_o is held.
  - gnt_i=1: go to ACTIVE next cycle.
  - gnt_i=0: stay in REQ (no timeout).
- State ACTIVE:
  - out_valid_o = FIFO not empty; req_o=0.
  - read_i pops the front. If the popped flit is TAIL or HEAD_TAIL, go to IDLE next cycle; otherwise stay in ACTIVE.
  - FIFO empty mid-packet: stay in ACTIVE with out_valid_o=0.
  - A HEAD flit seen mid-packet is forwarded unchanged and sets err_o.
- read_i outside ACTIVE, or with out_valid_o=0, is ignored.
- err_o clears only on rst.
- Occupancy counter width is $clog2(DEPTH+1). Read and write pointers wrap modulo DEPTH.

Decomposition:
- Package noc_pkg holds:
  - the flit_type_t enum (HEAD, BODY, TAIL, HEAD_TAIL);
  - FLIT_W and DEST_W defaults;
  - field-extract functions get_type() and get_dest().
- Sub-module flit_fifo: parameterized synchronous FIFO (push, pop, full, empty, front data, same-cycle push/pop when full).
- The top level holds the packet FSM, credit register and error flag.

Test Plan:
- Reset, then single flit HEAD_TAIL dest=4'h3 → req_o=1 and dest_o=3 two cycles after the write. gnt_i pulse → out_valid_o=1. read_i → credit_o=1 for one cycle, state returns to IDLE.
- 4-flit packet (HEAD, BODY, BODY, TAIL) written back-to-back, gnt_i held high, read_i held high → exactly 4 credit_o pulses, each one cycle after its pop. Flit order is preserved; IDLE after the TAIL pops.
- Fill 4 entries with gnt_i=0, then a 5th write → 5th flit dropped, err_o=1, no extra credit. Repeat with a simultaneous pop while full → write accepted, err_o stays 0.
- BODY flit arriving in IDLE → discarded, err_o=1, one credit_o pulse.
- rst asserted in ACTIVE with 3 flits stored → next cycle FIFO empty, credit_o=0, req_o=0, state=IDLE.
- read_i=1 while in REQ → no pop, no credit, flit_o unchanged.
